// File: rtl/arbiter_bus_request_buffer_pkg.sv
// Shared sizing for the arbiter ingress request buffer.
// Provides the default depth/width plus pointer and count types.
package arbiter_bus_request_buffer_pkg;

  localparam int unsigned ARB_FIFO_DEPTH = 16;
  localparam int unsigned ARB_BUS_WIDTH  = 8;
  localparam int unsigned ARB_PTR_W      = $clog2(ARB_FIFO_DEPTH);
  localparam int unsigned ARB_CNT_W      = ARB_PTR_W + 1;

  typedef logic [ARB_PTR_W-1:0] arb_ptr_t;
  typedef logic [ARB_CNT_W-1:0] arb_cnt_t;

endpackage

// File: rtl/arbiter_bus_request_buffer_mem.sv
// Simple dual-port FIFO storage: synchronous write, asynchronous read.
// Ports: i_clk, i_we/i_waddr/i_wdata write side, i_raddr/o_rdata read side.
module arbiter_bus_request_buffer_mem
  import arbiter_bus_request_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = ARB_FIFO_DEPTH,
  parameter int unsigned WIDTH = ARB_BUS_WIDTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/arbiter_bus_request_buffer.sv
// Per-lane ingress FIFO feeding one input of the N-in-1-out arbiter.
// Ports: ap_clk/ap_rst_n/flush, din handshake, arbiter grant/req/bus, fifo_count.
module arbiter_bus_request_buffer
  import arbiter_bus_request_buffer_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = ARB_BUS_WIDTH,
  parameter int unsigned FIFO_DEPTH  = ARB_FIFO_DEPTH,
  parameter int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   flush,
  input  logic                   din_valid,
  input  logic [BUS_WIDTH-1:0]   din,
  output logic                   din_ready,
  input  logic                   arbiter_grant,
  output logic                   arbiter_req,
  output logic                   arbiter_bus_valid,
  output logic [BUS_WIDTH-1:0]   arbiter_bus_out,
  output logic [COUNT_WIDTH-1:0] fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(FIFO_DEPTH);

  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_rst_done;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [BUS_WIDTH-1:0]   w_rdata;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Ready ignores a same-cycle pop: no bypass when full.
  assign din_ready = r_rst_done & ~flush & ~w_full;
  assign w_push    = din_valid & din_ready;
  assign w_pop     = arbiter_grant & ~w_empty & ~flush;

  assign arbiter_req = ~w_empty;
  assign fifo_count  = r_count;

  arbiter_bus_request_buffer_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUS_WIDTH),
    .AW    (PW)
  ) u_mem (
    .i_clk   (ap_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_rst_done        <= 1'b0;
      arbiter_bus_valid <= 1'b0;
      arbiter_bus_out   <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (flush) begin
        r_wr_ptr          <= '0;
        r_rd_ptr          <= '0;
        r_count           <= '0;
        arbiter_bus_valid <= 1'b0;
        arbiter_bus_out   <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count
                 + COUNT_WIDTH'(w_push)
                 - COUNT_WIDTH'(w_pop);
        // Bus is zeroed on idle cycles rather than held.
        arbiter_bus_valid <= w_pop;
        arbiter_bus_out   <= w_pop ? w_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_bus_request_buffer.sv
// Directed self-checking bench for arbiter_bus_request_buffer.
// Drives and samples 1 time unit after each rising edge.
module tb_arbiter_bus_request_buffer;

  localparam int BW = 8;
  localparam int FD = 16;
  localparam int CW = 5;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          flush;
  logic          din_valid;
  logic [BW-1:0] din;
  logic          din_ready;
  logic          arbiter_grant;
  logic          arbiter_req;
  logic          arbiter_bus_valid;
  logic [BW-1:0] arbiter_bus_out;
  logic [CW-1:0] fifo_count;

  int n_cmp;
  int n_err;

  arbiter_bus_request_buffer #(
    .BUS_WIDTH   (BW),
    .FIFO_DEPTH  (FD),
    .COUNT_WIDTH (CW)
  ) dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (ap_rst_n),
    .flush             (flush),
    .din_valid         (din_valid),
    .din               (din),
    .din_ready         (din_ready),
    .arbiter_grant     (arbiter_grant),
    .arbiter_req       (arbiter_req),
    .arbiter_bus_valid (arbiter_bus_valid),
    .arbiter_bus_out   (arbiter_bus_out),
    .fifo_count        (fifo_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ap_rst_n      = 1'b0;
    flush         = 1'b0;
    din_valid     = 1'b0;
    din           = '0;
    arbiter_grant = 1'b0;

    // Reset held for 5 edges
    repeat (5) step();
    chk("rst_ready", 32'(din_ready), 0);
    chk("rst_req",   32'(arbiter_req), 0);
    chk("rst_cnt",   32'(fifo_count), 0);
    chk("rst_bv",    32'(arbiter_bus_valid), 0);
    ap_rst_n = 1'b1;
    #1;
    chk("rel_ready0", 32'(din_ready), 0);
    step();
    chk("rel_ready1", 32'(din_ready), 1);
    chk("rel_req",    32'(arbiter_req), 0);
    chk("rel_cnt",    32'(fifo_count), 0);

    // Basic path: push 0xA5 with grant held
    din = 8'hA5; din_valid = 1'b1; arbiter_grant = 1'b1;
    step();
    din_valid = 1'b0;
    chk("bas_req1", 32'(arbiter_req), 1);
    chk("bas_cnt1", 32'(fifo_count), 1);
    chk("bas_bv1",  32'(arbiter_bus_valid), 0);
    step();
    chk("bas_bv2",  32'(arbiter_bus_valid), 1);
    chk("bas_out2", 32'(arbiter_bus_out), 32'hA5);
    chk("bas_req2", 32'(arbiter_req), 0);
    step();
    chk("bas_bv3",  32'(arbiter_bus_valid), 0);
    chk("bas_out3", 32'(arbiter_bus_out), 0);
    arbiter_grant = 1'b0;

    // Fill to full
    for (int i = 0; i < FD; i++) begin
      din = BW'(i); din_valid = 1'b1;
      step();
    end
    chk("full_cnt",   32'(fifo_count), FD);
    chk("full_ready", 32'(din_ready), 0);
    din = 8'hEE;
    step();
    din_valid = 1'b0;
    chk("full_17th",  32'(fifo_count), FD);

    // Drain in order
    arbiter_grant = 1'b1;
    for (int i = 0; i < FD; i++) begin
      step();
      chk("drain_bv",  32'(arbiter_bus_valid), 1);
      chk("drain_out", 32'(arbiter_bus_out), i);
    end
    chk("drain_cnt", 32'(fifo_count), 0);

    // Spurious grants on empty
    for (int i = 0; i < 3; i++) begin
      step();
      chk("spur_bv",  32'(arbiter_bus_valid), 0);
      chk("spur_out", 32'(arbiter_bus_out), 0);
      chk("spur_cnt", 32'(fifo_count), 0);
    end
    arbiter_grant = 1'b0;

    // Simultaneous push and pop at count=1
    din = 8'h11; din_valid = 1'b1;
    step();
    chk("sim_cnt0", 32'(fifo_count), 1);
    din = 8'h22; arbiter_grant = 1'b1;
    step();
    din_valid = 1'b0;
    chk("sim_out1", 32'(arbiter_bus_out), 32'h11);
    chk("sim_cnt1", 32'(fifo_count), 1);
    step();
    arbiter_grant = 1'b0;
    chk("sim_out2", 32'(arbiter_bus_out), 32'h22);
    chk("sim_cnt2", 32'(fifo_count), 0);

    // Flush at count=5 with push and grant
    for (int i = 0; i < 5; i++) begin
      din = BW'(8'h30 + i); din_valid = 1'b1;
      step();
    end
    chk("fl_cnt5", 32'(fifo_count), 5);
    flush = 1'b1; din = 8'h99; arbiter_grant = 1'b1;
    #1;
    chk("fl_ready", 32'(din_ready), 0);
    step();
    flush = 1'b0; din_valid = 1'b0; arbiter_grant = 1'b0;
    chk("fl_cnt",  32'(fifo_count), 0);
    chk("fl_bv",   32'(arbiter_bus_valid), 0);
    chk("fl_out",  32'(arbiter_bus_out), 0);
    chk("fl_req",  32'(arbiter_req), 0);
    din = 8'h5A; din_valid = 1'b1;
    step();
    din_valid = 1'b0; arbiter_grant = 1'b1;
    step();
    arbiter_grant = 1'b0;
    chk("fl_post", 32'(arbiter_bus_out), 32'h5A);

    // Async reset while bus_valid is high
    din = 8'h77; din_valid = 1'b1;
    step();
    din_valid = 1'b0; arbiter_grant = 1'b1;
    step();
    arbiter_grant = 1'b0;
    chk("ar_bv1",  32'(arbiter_bus_valid), 1);
    chk("ar_out1", 32'(arbiter_bus_out), 32'h77);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("ar_bv0",  32'(arbiter_bus_valid), 0);
    chk("ar_out0", 32'(arbiter_bus_out), 0);
    chk("ar_rdy0", 32'(din_ready), 0);
    ap_rst_n = 1'b1;
    step();
    chk("ar_rdy1", 32'(din_ready), 1);
    chk("ar_cnt",  32'(fifo_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arbiter_bus_request_buffer.md
Name: arbiter_bus_request_buffer

Overview:
Per-requester ingress stage that sits directly upstream of one input lane of arbiter_bus_N_in_1_out.
- Accepts words from a producing engine over a valid/ready handshake and stores them in a FIFO.
- Raises arbiter_req while any word is held.
- On each arbiter grant, pops one word and presents it as arbiter_bus_in[i] / arbiter_bus_valid[i] for that lane.
- One instance is placed per arbiter lane.

Parameters:
BUS_WIDTH, 8, payload width; must equal the arbiter's BUS_WIDTH.
FIFO_DEPTH, 16, entry count; power of two, >= 2.
COUNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of the occupancy counter.

Ports:
ap_clk  input  1  clock; all logic on the rising edge.
ap_rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous discard of all buffered words.
din_valid  input  1  producer word valid.
din  input  BUS_WIDTH  producer payload.
din_ready  output  1  buffer can accept a word this cycle.
arbiter_grant  input  1  this lane's bit of the arbiter grant vector.
arbiter_req  output  1  this lane's request bit to the arbiter.
arbiter_bus_valid  output  1  bus_out carries a popped word this cycle.
arbiter_bus_out  output  BUS_WIDTH  popped payload to the arbiter bus input.
fifo_count  output  COUNT_WIDTH  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (ap_rst_n=0, asynchronous) clears:
  - read/write pointers, count, rst_done, arbiter_bus_valid and arbiter_bus_out;
  - so din_ready=0, arbiter_req=0, fifo_count=0.
  - Memory contents are not reset.
- rst_done sets on the first rising edge after ap_rst_n deasserts. din_ready therefore rises one cycle after reset release.
- din_ready = rst_done & ~flush & (count != FIFO_DEPTH). It is combinational from registers plus flush and does not depend on the same-cycle pop, so there is no full-bypass.
- Push: din_valid & din_ready writes din at wr_ptr; wr_ptr increments with natural wrap at FIFO_DEPTH.
- Pop: arbiter_grant & (count != 0) & ~flush reads the word at rd_ptr; rd_ptr increments with wrap.
  - Next cycle: arbiter_bus_valid=1 and arbiter_bus_out=the popped word. Latency is 1 cycle, registered output.
- No pop cycle: arbiter_bus_valid=0 and arbiter_bus_out=0 on the next cycle. The bus output is zeroed, not held.
- Grant while empty (spurious grant from the arbiter's registered grant latency) is ignored: no pointer change, bus_valid=0.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at count=1, where the pop takes the old head.
- Push to an empty FIFO: the word is not poppable in the same cycle (no empty-bypass). arbiter_req rises the next cycle.
- arbiter_req = (count != 0). After the last pop it falls the cycle after the pop. Any grant still arriving from the pipelined arbiter falls under the spurious-grant rule.
- Flush:
  - Has priority over push and pop in that cycle.
  - Next cycle: pointers=0, count=0, arbiter_bus_valid=0, arbiter_bus_out=0.
  - din_ready=0 during the flush cycle; the input word offered in that cycle is not accepted.
- fifo_count = count register, range 0..FIFO_DEPTH. COUNT_WIDTH holds FIFO_DEPTH exactly.
- Reset mid-operation: immediate asynchronous clear. Any in-flight bus word is dropped and bus_valid drops without waiting for a clock edge.
- The producer must hold din/din_valid stable until accepted; the block does not check this.

Decomposition:
- Package PKG_ARBITER:
  - typedef for the pointer type, sized $clog2(FIFO_DEPTH);
  - typedef for the count type, sized COUNT_WIDTH;
  - localparam default FIFO_DEPTH shared with arbiter_bus_N_in_1_out instantiation wrappers.
- One sub-module: arbiter_bus_request_buffer_mem.
  - Simple dual-port memory, FIFO_DEPTH x BUS_WIDTH.
  - Synchronous write; read returns data in the same cycle as the pop, feeding the output register.
  - Inferable as distributed RAM.
- Pointers, count, handshake and output register stay in the top module.

Test Plan:
- Reset release: ap_rst_n low 5 cycles then high -> din_ready=0 for the first post-release edge, 1 afterwards; arbiter_req=0 and fifo_count=0 throughout.
- Basic path: push 0xA5 at cycle t; grant held high -> arbiter_req=1 at t+1; pop at t+1; arbiter_bus_valid=1 and arbiter_bus_out=0xA5 at t+2; req=0 at t+2.
- Full: FIFO_DEPTH=16, push 0x00..0x0F with no grant -> fifo_count=16, din_ready=0, a 17th din_valid is not accepted. Then grant 16 cycles -> bus_out sequence 0x00..0x0F in order, fifo_count=0.
- Simultaneous push and pop: count=1 holding 0x11; push 0x22 and grant in the same cycle -> bus_out=0x11 next cycle, fifo_count stays 1; next grant yields 0x22.
- Spurious grant: after the FIFO empties, grant held 3 more cycles -> arbiter_bus_valid=0, bus_out=0, pointers unchanged, fifo_count=0.
- Flush and async reset:
  - count=5, assert flush together with din_valid and grant -> next cycle fifo_count=0, bus_valid=0, the input word is not accepted.
  - Separately, ap_rst_n pulsed low mid-cycle while bus_valid=1 -> bus_valid=0 immediately without a clock edge.
